draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Sequences a full screen redraw of the reversi display through the single VGA-adapter plot port. On `start` it enables the board-grid drawer and forwards its pixels. It then scans a snapshot of the 8x8 board state and fills a 9x9 square for every occupied cell and for the cursor cell, using an internal counter unit. It sits between the game FSM, which supplies `start`, the board state and the cursor, and the VGA adapter.

## Interface
- `BOARD_X0`, default 27: x of the grid top-left pixel.
- `BOARD_Y0`, default 10: y of the grid top-left pixel.
- `PITCH`, default 13: grid line spacing in pixels.
- `INSET`, default 3: offset from a grid line to the piece square.
- `PIECE_W`, default 9: side length of the piece square.
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: redraw request; accepted only in IDLE.
- `board_state` in 128: cell i in bits [2i+1:2i]; i = row*8 + col; 00 empty, 01 black, 10 white, 11 treated as empty.
- `cursor_row`, `cursor_col` in 3 each: cursor cell.
- `busy` out 1: high from the cycle after acceptance until `done`, inclusive.
- `done` out 1: one-cycle pulse when the redraw is complete.
- `board_en` out 1: enable to the grid drawer.
- `board_done` in 1: the grid drawer's completion pulse.
- `board_x` in 8, `board_y` in 7, `board_colour` in 3: the grid drawer's pixel.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3, `vga_plot` out 1: plot port to the VGA adapter.

## Operation
- States: IDLE, BOARD, SCAN, PIECE, DONE.
- IDLE:
  - On `start`, latch `board_state`, `cursor_row` and `cursor_col` into a snapshot, clear cell index `idx`, go to BOARD.
  - `start` in any other state is ignored; it is not queued.
- BOARD:
  - `board_en`=1; the grid drawer's pixel is muxed to the `vga_*` outputs.
  - `vga_plot` = `board_en` & !`board_done`.
  - On `board_done`, go to SCAN.
- SCAN, one cycle per cell:
  - r = `idx`[5:3], c = `idx`[2:0].
  - Cell needs drawing if code is 01 or 10, or if (r,c) is the cursor.
  - If drawing is needed: start the fill, go to PIECE.
  - Else if `idx`==63: go to DONE.
  - Else: `idx`++.
- PIECE:
  - Fill origin: x = `BOARD_X0`+`PITCH`*c+`INSET`, y = `BOARD_Y0`+`PITCH`*r+`INSET`.
  - Scan order is raster, x fastest, 81 pixels.
  - Colour: 01 → 3'b000, 10 → 3'b111, empty cursor cell → 3'b110.
  - A cursor on an occupied cell draws the piece colour.
  - After the last pixel: if `idx`==63 go to DONE, else `idx`++ and go to SCAN.
- DONE: `done`=1 for one cycle, go to IDLE.
- Width rules:
  - Maximum x = 27+91+3+8 = 129; maximum y = 10+91+11 = 112.
  - Compute in 8/7 bits; no overflow is possible with the default parameters.

## Timing
- Reset values: state IDLE, `idx`=0, snapshot 0, and every output 0 (`busy`, `done`, `board_en`, `vga_plot`, `vga_x`, `vga_y`, `vga_colour`).
- Reset mid-operation: abort immediately to IDLE; `board_en` drops, so the grid drawer stops.
- `start` sampled at edge t: BOARD is active from t+1, with `board_en`=1 from t+1.
- The grid drawer plots 3816 pixels; the `board_done` cycle itself is not plotted.
- SCAN costs 1 cycle per skipped cell.
- PIECE pixel k (k = 0..80) is plotted on the k-th cycle in PIECE.
- `vga_plot`=0 in IDLE, SCAN and DONE.
- Outside PIECE and BOARD, `vga_x`, `vga_y` and `vga_colour` hold their last value.
- Snapshot: changes to `board_state` or the cursor during `busy` have no effect.

## Structure
- Package `draw_pkg`:
  - state enum;
  - cell codes EMPTY, BLACK, WHITE;
  - colours COL_BLACK, COL_WHITE, COL_CURSOR, COL_GRID=3'b101;
  - geometry defaults.
- Sub-module `piece_fill`:
  - inputs `clk`, `resetn`, `go`, `origin_x`, `origin_y`;
  - outputs `x`, `y`, `plot`, `last`;
  - 4-bit column and row counters, 0..`PIECE_W`-1.
- The scheduler holds the FSM, `idx`, the snapshot and the output mux.

## Test plan
- Empty board, cursor (0,0):
  - the 3816 grid pixels are forwarded;
  - then exactly 81 plots of 3'b110 over x 30..38, y 13..21;
  - then `done` pulses once; `busy` is low the cycle after.
- Cell 63 = 10, cursor (7,7): exactly one fill, 3'b111, over x 121..129, y 104..112. Cursor does not change the colour.
- Cells 0 = 01 and 9 = 10, cursor (3,4):
  - three fills in order: black at (30,13), white at (43,26), yellow at (82,52);
  - 243 piece plots in total.
- All cells 11, cursor (2,2): only the cursor fill; code 11 is never drawn.
- `start` pulsed during PIECE and `board_state` changed mid-run: ignored; output matches the original snapshot; exactly one `done`.
- `resetn` low during BOARD and again during PIECE: all outputs 0 asynchronously. A new `start` after release gives a complete, correct redraw.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the reversi screen redraw path.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOARD,
        ST_SCAN,
        ST_PIECE,
        ST_DONE
    } state_t;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_CURSOR = 3'b110;
    localparam logic [2:0] COL_GRID   = 3'b101;

    localparam int DEF_BOARD_X0 = 27;
    localparam int DEF_BOARD_Y0 = 10;
    localparam int DEF_PITCH    = 13;
    localparam int DEF_INSET    = 3;
    localparam int DEF_PIECE_W  = 9;

endpackage

// File: rtl/draw_scheduler_if.sv
// Grid-drawer pixel input and VGA-adapter plot output of the redraw scheduler.
// vga_plot qualifies vga_x/y/colour for exactly one cycle; there is no back-pressure.
interface draw_scheduler_if;
    logic       board_en;
    logic       board_done;
    logic [7:0] board_x;
    logic [6:0] board_y;
    logic [2:0] board_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output board_en, vga_x, vga_y, vga_colour, vga_plot,
        input  board_done, board_x, board_y, board_colour
    );

    modport slave (
        input  board_en, vga_x, vga_y, vga_colour, vga_plot,
        output board_done, board_x, board_y, board_colour
    );
endinterface

// File: rtl/draw_scheduler_piece_fill.sv
// Raster fill of a PIECE_W x PIECE_W square; pixel 0 is presented the cycle after go.
module piece_fill
    import draw_pkg::*;
#(
    parameter int PIECE_W = DEF_PIECE_W
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [7:0] origin_x,
    input  logic [6:0] origin_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       plot,
    output logic       last
);

    localparam logic [3:0] LAST_POS = 4'(PIECE_W - 1);

    logic       active_q, active_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;

    always_comb begin
        active_d = active_q;
        col_d    = col_q;
        row_d    = row_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        if (go) begin
            active_d = 1'b1;
            col_d    = 4'd0;
            row_d    = 4'd0;
            ox_d     = origin_x;
            oy_d     = origin_y;
        end else if (active_q) begin
            if (col_q == LAST_POS) begin
                col_d = 4'd0;
                if (row_q == LAST_POS) begin
                    active_d = 1'b0;
                end else begin
                    row_d = row_q + 4'd1;
                end
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            col_q    <= 4'd0;
            row_q    <= 4'd0;
            ox_q     <= 8'd0;
            oy_q     <= 7'd0;
        end else begin
            active_q <= active_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
        end
    end

    assign x    = ox_q + {4'd0, col_q};
    assign y    = oy_q + {3'd0, row_q};
    assign plot = active_q;
    assign last = active_q && (col_q == LAST_POS) && (row_q == LAST_POS);

endmodule

// File: rtl/draw_scheduler.sv
// Full-screen redraw sequencer: grid drawer first, then one filled square per
// occupied cell and for the cursor, all through the single VGA plot port.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int BOARD_X0 = DEF_BOARD_X0,
    parameter int BOARD_Y0 = DEF_BOARD_Y0,
    parameter int PITCH    = DEF_PITCH,
    parameter int INSET    = DEF_INSET,
    parameter int PIECE_W  = DEF_PIECE_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [127:0]      board_state,
    input  logic [2:0]        cursor_row,
    input  logic [2:0]        cursor_col,
    output logic              busy,
    output logic              done,
    draw_scheduler_if.master  vif,
    output state_t            dbg_state
);

    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [127:0] snap_q, snap_d;
    logic [2:0]   crow_q, crow_d, ccol_q, ccol_d;
    logic         busy_q, busy_d, done_q, done_d, board_en_q, board_en_d;
    logic [2:0]   pcol_q, pcol_d;
    logic [7:0]   hold_x_q, hold_x_d;
    logic [6:0]   hold_y_q, hold_y_d;
    logic [2:0]   hold_c_q, hold_c_d;

    logic [2:0]   scan_r, scan_c;
    logic [1:0]   code;
    logic         is_cursor, need_draw, fill_go;
    logic [2:0]   cell_colour;
    logic [7:0]   org_x, fill_x;
    logic [6:0]   org_y, fill_y;
    logic         fill_plot, fill_last;

    assign scan_r    = idx_q[5:3];
    assign scan_c    = idx_q[2:0];
    assign code      = snap_q[{idx_q, 1'b0} +: 2];
    assign is_cursor = (scan_r == crow_q) && (scan_c == ccol_q);
    assign need_draw = (code == BLACK) || (code == WHITE) || is_cursor;
    assign org_x     = 8'(BOARD_X0 + INSET) + 8'(PITCH) * {5'd0, scan_c};
    assign org_y     = 7'(BOARD_Y0 + INSET) + 7'(PITCH) * {4'd0, scan_r};

    // The piece colour wins over the cursor highlight on an occupied cell.
    always_comb begin
        case (code)
            BLACK:   cell_colour = COL_BLACK;
            WHITE:   cell_colour = COL_WHITE;
            default: cell_colour = COL_CURSOR;
        endcase
    end

    piece_fill #(.PIECE_W(PIECE_W)) u_fill (
        .clk      (clk),
        .resetn   (resetn),
        .go       (fill_go),
        .origin_x (org_x),
        .origin_y (org_y),
        .x        (fill_x),
        .y        (fill_y),
        .plot     (fill_plot),
        .last     (fill_last)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        crow_d     = crow_q;
        ccol_d     = ccol_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        board_en_d = board_en_q;
        pcol_d     = pcol_q;
        fill_go    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d     = board_state;
                    crow_d     = cursor_row;
                    ccol_d     = cursor_col;
                    idx_d      = 6'd0;
                    busy_d     = 1'b1;
                    board_en_d = 1'b1;
                    state_d    = ST_BOARD;
                end
            end
            ST_BOARD: begin
                if (vif.board_done) begin
                    board_en_d = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (need_draw) begin
                    fill_go = 1'b1;
                    pcol_d  = cell_colour;
                    state_d = ST_PIECE;
                end else if (idx_q == 6'd63) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_PIECE: begin
                if (fill_last) begin
                    if (idx_q == 6'd63) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel mux; whatever is shown is remembered so other states hold it.
    always_comb begin
        hold_x_d     = hold_x_q;
        hold_y_d     = hold_y_q;
        hold_c_d     = hold_c_q;
        vif.vga_plot = 1'b0;
        if (state_q == ST_BOARD) begin
            hold_x_d     = vif.board_x;
            hold_y_d     = vif.board_y;
            hold_c_d     = vif.board_colour;
            vif.vga_plot = board_en_q & ~vif.board_done;
        end else if (state_q == ST_PIECE) begin
            hold_x_d     = fill_x;
            hold_y_d     = fill_y;
            hold_c_d     = pcol_q;
            vif.vga_plot = fill_plot;
        end
        vif.vga_x      = hold_x_d;
        vif.vga_y      = hold_y_d;
        vif.vga_colour = hold_c_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            snap_q     <= 128'd0;
            crow_q     <= 3'd0;
            ccol_q     <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            board_en_q <= 1'b0;
            pcol_q     <= 3'd0;
            hold_x_q   <= 8'd0;
            hold_y_q   <= 7'd0;
            hold_c_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            crow_q     <= crow_d;
            ccol_q     <= ccol_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            board_en_q <= board_en_d;
            pcol_q     <= pcol_d;
            hold_x_q   <= hold_x_d;
            hold_y_q   <= hold_y_d;
            hold_c_q   <= hold_c_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign vif.board_en = board_en_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: a grid-drawer model feeds pixels, a
// reference model predicts every plotted pixel, a monitor checks each plot.
module tb_draw_scheduler;
  import draw_pkg::*;

  localparam int GRID_PIX = 3816;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [127:0] board_state = '0;
  logic [2:0]   cursor_row = '0;
  logic [2:0]   cursor_col = '0;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  draw_scheduler_if dif();

  draw_scheduler dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .board_state (board_state),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .busy        (busy),
    .done        (done),
    .vif         (dif),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] last_exp;

  function automatic logic [17:0] grid_pix(input int n);
    logic [7:0] gx;
    logic [6:0] gy;
    gx = 8'(n % 130);
    gy = 7'((n * 7) % 113);
    return {gx, gy, COL_GRID};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // grid drawer model: GRID_PIX pixels while enabled, then a done pulse
  initial begin
    int n;
    n = 0;
    dif.board_done = 1'b0;
    dif.board_x = '0;
    dif.board_y = '0;
    dif.board_colour = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!dif.board_en) begin
        n = 0;
        dif.board_done = 1'b0;
      end else if (n < GRID_PIX) begin
        {dif.board_x, dif.board_y, dif.board_colour} = grid_pix(n);
        n++;
      end else begin
        dif.board_done = 1'b1;
      end
    end
  end

  // monitor: pop and compare on every plot
  initial begin
    logic [17:0] got, e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (dif.vga_plot) begin
          plot_cnt++;
          got = {dif.vga_x, dif.vga_y, dif.vga_colour};
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL plot_unexpected got=%h want=none", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              bad++;
              $display("FAIL plot_pixel got x=%0d y=%0d c=%b want x=%0d y=%0d c=%b",
                       got[17:10], got[9:3], got[2:0], e[17:10], e[9:3], e[2:0]);
            end
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // reference model: grid pixels, then cells in row-major order
  task automatic build_expected(input logic [127:0] bs, input logic [2:0] cr,
                                input logic [2:0] cc, output int npiece);
    logic [1:0]  cd;
    logic [2:0]  col;
    logic [17:0] p;
    bit          draw;
    npiece = 0;
    exp_q.delete();
    for (int n = 0; n < GRID_PIX; n++) begin
      p = grid_pix(n);
      exp_q.push_back(p);
    end
    last_exp = p;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cd = bs[(r * 8 + c) * 2 +: 2];
        draw = 1'b1;
        if (cd == 2'b01) col = 3'b000;
        else if (cd == 2'b10) col = 3'b111;
        else if (r == int'(cr) && c == int'(cc)) col = 3'b110;
        else draw = 1'b0;
        if (draw) begin
          npiece++;
          for (int py = 0; py < 9; py++) begin
            for (int px = 0; px < 9; px++) begin
              p = {8'(27 + 13 * c + 3 + px), 7'(10 + 13 * r + 3 + py), col};
              exp_q.push_back(p);
            end
          end
          last_exp = p;
        end
      end
    end
  endtask

  function automatic logic [127:0] rand_board();
    logic [127:0] b;
    int v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom_range(0, 7);
      case (v)
        0: b[2 * i +: 2] = 2'b01;
        1: b[2 * i +: 2] = 2'b10;
        2: b[2 * i +: 2] = 2'b11;
        default: b[2 * i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  task automatic wait_state(input state_t s, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // driver: full redraw; poke pulses start and scrambles inputs during PIECE
  task automatic run_redraw(input string nm, input logic [127:0] bs, input logic [2:0] cr,
                            input logic [2:0] cc, input bit poke);
    int  npiece;
    bit  seen, ok;
    board_state = bs;
    cursor_row = cr;
    cursor_col = cc;
    build_expected(bs, cr, cc, npiece);
    plot_cnt = 0;
    done_cnt = 0;
    pulse_start();
    check({nm, "_busy_start"}, 32'(busy), 32'd1);
    check({nm, "_board_en_start"}, 32'(dif.board_en), 32'd1);
    if (poke) begin
      wait_state(ST_PIECE, ok);
      check({nm, "_reach_piece"}, 32'(ok), 32'd1);
      start = 1'b1;
      board_state = ~bs;
      cursor_row = cr + 3'd1;
      cursor_col = cc + 3'd2;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, "_busy_at_done"}, 32'(busy), 32'd1);
      check({nm, "_hold_pixel"}, 32'({dif.vga_x, dif.vga_y, dif.vga_colour}), 32'(last_exp));
      @(negedge clk);
      check({nm, "_busy_after"}, 32'(busy), 32'd0);
      check({nm, "_done_once"}, 32'(done), 32'd0);
      check({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({nm, "_plot_count"}, 32'(plot_cnt), 32'(GRID_PIX + 81 * npiece));
      repeat (10) @(negedge clk);
      check({nm, "_done_count"}, 32'(done_cnt), 32'd1);
      check({nm, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, 32'(busy), 32'd0);
    check({nm, "_done"}, 32'(done), 32'd0);
    check({nm, "_board_en"}, 32'(dif.board_en), 32'd0);
    check({nm, "_plot"}, 32'(dif.vga_plot), 32'd0);
    check({nm, "_xyc"}, 32'({dif.vga_x, dif.vga_y, dif.vga_colour}), 32'd0);
    check({nm, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic reset_during(input string nm, input state_t s);
    int  npiece;
    bit  ok;
    logic [127:0] bs;
    bs = rand_board();
    bs[1:0] = 2'b10;
    board_state = bs;
    build_expected(bs, 3'd5, 3'd5, npiece);
    pulse_start();
    wait_state(s, ok);
    check({nm, "_reach"}, 32'(ok), 32'd1);
    repeat ($urandom_range(2, 40)) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs(nm);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_redraw({nm, "_after"}, rand_board(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
  endtask

  initial begin
    logic [127:0] b;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2;
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_redraw("empty", 128'd0, 3'd0, 3'd0, 1'b0);

    b = '0;
    b[127:126] = 2'b10;
    run_redraw("cell63", b, 3'd7, 3'd7, 1'b0);

    b = '0;
    b[1:0] = 2'b01;
    b[19:18] = 2'b10;
    run_redraw("three", b, 3'd3, 3'd4, 1'b0);

    b = '1;
    run_redraw("all11", b, 3'd2, 3'd2, 1'b0);

    b = rand_board();
    b[2 * 20 +: 2] = 2'b01;
    run_redraw("poke", b, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);

    reset_during("rst_board", ST_BOARD);
    reset_during("rst_piece", ST_PIECE);

    for (int t = 0; t < 2; t++) begin
      run_redraw("random", rand_board(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
